// File: rtl/bf_coef_loader_if.sv
// Coefficient write channel for the beamformer loader.
// Valid/ready beats carrying an antenna index and one signed weight.
interface bf_coef_loader_if #(
  parameter int NN      = 4,
  parameter int b_width = 16,
  parameter int IDX_W   = (NN < 2) ? 1 : $clog2(NN)
);
  logic               wr_valid;
  logic               wr_ready;
  logic [IDX_W-1:0]   wr_idx;
  logic [b_width-1:0] wr_data;
  logic               wr_last;

  modport master (
    output wr_valid,
    output wr_idx,
    output wr_data,
    output wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_idx,
    input  wr_data,
    input  wr_last,
    output wr_ready
  );
endinterface

// File: rtl/bf_coef_loader.sv
// Double-buffered beamformer coefficient loader.
// Sets fill a shadow bank and swap into the active bank on an epoch strobe.
module bf_coef_loader #(
  parameter int NN      = 4,
  parameter int b_width = 16,
  parameter int IDX_W   = (NN < 2) ? 1 : $clog2(NN)
) (
  input  logic                    clk,
  input  logic                    reset,
  bf_coef_loader_if.slave         wr,
  input  logic                    abort,
  input  logic                    epoch,
  output logic [NN*b_width-1:0]   argsB,
  output logic                    coef_valid,
  output logic                    applied,
  output logic                    err
);

  localparam int IW = (NN < 2) ? 1 : $clog2(NN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PEND
  } state_e;

  state_e              state_q, state_d;
  logic [NN-1:0]       mask_q, mask_d;
  logic [b_width-1:0]  shadow_q [NN];
  logic [NN*b_width-1:0] active_q;
  logic                coef_valid_q;
  logic                applied_q;
  logic                err_q, err_d;

  logic                accept;
  logic                in_range;
  logic [IW-1:0]       widx;
  logic [NN-1:0]       mask_hit;
  logic                wen;
  logic                commit;

  assign wr.wr_ready = (state_q != S_PEND);
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign in_range    = 32'(wr.wr_idx) < NN;
  assign widx        = wr.wr_idx[IW-1:0];
  assign mask_hit    = in_range ? (mask_q | (NN'(1) << widx)) : mask_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    wen     = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (abort && state_q == S_LOAD) begin
          mask_d  = '0;
          state_d = S_IDLE;
        end else if (accept) begin
          wen   = in_range;
          err_d = !in_range;
          if (wr.wr_last) begin
            if (&mask_hit) begin
              mask_d  = mask_hit;
              state_d = S_PEND;
            end else begin
              err_d   = 1'b1;
              mask_d  = '0;
              state_d = S_IDLE;
            end
          end else begin
            mask_d  = mask_hit;
            state_d = S_LOAD;
          end
        end
      end
      S_PEND: begin
        // abort wins over a coincident epoch
        if (abort) begin
          mask_d  = '0;
          state_d = S_IDLE;
        end else if (epoch) begin
          commit  = 1'b1;
          mask_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        mask_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      coef_valid_q <= 1'b0;
      applied_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      coef_valid_q <= coef_valid_q | commit;
      applied_q    <= commit;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NN; i++) shadow_q[i] <= '0;
    end else if (wen) begin
      shadow_q[widx] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
    end else if (commit) begin
      for (int i = 0; i < NN; i++)
        active_q[i*b_width +: b_width] <= shadow_q[i];
    end
  end

  assign argsB      = active_q;
  assign coef_valid = coef_valid_q;
  assign applied    = applied_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bf_coef_loader.sv
// Scoreboard bench for bf_coef_loader (NN=4, 16-bit, 3-bit index).
// Drives on the falling edge and samples outputs there too.
module tb_bf_coef_loader;

  localparam int NN = 4;
  localparam int BW = 16;
  localparam int IW = 3;
  localparam int AW = NN * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          abort;
  logic          epoch;
  logic [AW-1:0] argsB;
  logic          coef_valid;
  logic          applied;
  logic          err;

  bf_coef_loader_if #(.NN(NN), .b_width(BW), .IDX_W(IW)) bus ();

  bf_coef_loader #(.NN(NN), .b_width(BW), .IDX_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (bus),
    .abort      (abort),
    .epoch      (epoch),
    .argsB      (argsB),
    .coef_valid (coef_valid),
    .applied    (applied),
    .err        (err)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] cur_active = '0;
  logic [AW-1:0] got;

  function automatic logic [AW-1:0] pack(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic beat(int idx, int data, bit last);
    bus.wr_valid = 1'b1;
    bus.wr_idx   = 3'(idx);
    bus.wr_data  = 16'(data);
    bus.wr_last  = last;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  task automatic full_set(int a, int b, int c, int d);
    beat(0, a, 0);
    beat(1, b, 0);
    beat(2, c, 0);
    beat(3, d, 1);
  endtask

  task automatic fire_epoch(logic [AW-1:0] e);
    exp_q.push_back(e);
    epoch = 1'b1;
    @(negedge clk);
    epoch = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({argsB, coef_valid, applied, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%b%b%b want 0",
               argsB, coef_valid, applied, err);
    end
    reset = 1'b0;
    @(negedge clk);
    n_assert++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", bus.wr_ready);
    end
  endtask

  task automatic test_incomplete();
    beat(0, 7, 0);
    beat(1, 8, 0);
    beat(3, 9, 1);
    n_assert++;
    if (err !== 1'b1 || bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL incomplete_err: err %b ready %b want 1 1",
               err, bus.wr_ready);
    end
    epoch = 1'b1;
    @(negedge clk);
    epoch = 1'b0;
    @(negedge clk);
    n_assert++;
    if (argsB !== '0 || applied !== 1'b0 || coef_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL incomplete_noapply: argsB %h applied %b cv %b want 0",
               argsB, applied, coef_valid);
    end
  endtask

  task automatic test_commit();
    full_set(100, -200, 300, -400);
    n_assert++;
    if (bus.wr_ready !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_pend: ready %b err %b want 0 0",
               bus.wr_ready, err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_assert++;
      if (argsB !== cur_active || applied !== 1'b0) begin
        n_fail++;
        $display("FAIL commit_hold%0d: argsB %h applied %b want %h 0",
                 i, argsB, applied, cur_active);
      end
    end
    epoch = 1'b1;
    n_assert++;
    if (argsB !== cur_active) begin
      n_fail++;
      $display("FAIL commit_early: argsB %h want %h", argsB, cur_active);
    end
    exp_q.push_back(pack(100, -200, 300, -400));
    @(negedge clk);
    epoch = 1'b0;
    n_assert++;
    if (applied !== 1'b1 || coef_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_applied: applied %b cv %b want 1 1",
               applied, coef_valid);
    end else begin
      got = exp_q.pop_front();
      if (argsB !== got) begin
        n_fail++;
        $display("FAIL commit_args: argsB %h want %h", argsB, got);
      end
      cur_active = got;
    end
    @(negedge clk);
    n_assert++;
    if (applied !== 1'b0 || bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_pulse: applied %b ready %b want 0 1",
               applied, bus.wr_ready);
    end
  endtask

  task automatic test_bad_idx();
    beat(0, 11, 0);
    beat(5, 999, 0);
    n_assert++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL badidx_err: got %b want 1", err);
    end
    beat(1, -22, 0);
    n_assert++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL badidx_pulse: got %b want 0", err);
    end
    beat(2, 33, 0);
    beat(3, -44, 1);
    fire_epoch(pack(11, -22, 33, -44));
    n_assert++;
    if (applied !== 1'b1) begin
      n_fail++;
      $display("FAIL badidx_applied: got %b want 1", applied);
    end else begin
      got = exp_q.pop_front();
      if (argsB !== got) begin
        n_fail++;
        $display("FAIL badidx_args: argsB %h want %h", argsB, got);
      end
      cur_active = got;
    end
  endtask

  task automatic test_abort();
    full_set(1, 2, 3, 4);
    n_assert++;
    if (bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pend: ready %b want 0", bus.wr_ready);
    end
    abort = 1'b1;
    epoch = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    epoch = 1'b0;
    n_assert++;
    if (applied !== 1'b0 || argsB !== cur_active ||
        bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pend_epoch: applied %b argsB %h ready %b want 0 %h 1",
               applied, argsB, bus.wr_ready, cur_active);
    end
    // abort mid-load drops the partial set; a fresh incomplete set errs
    beat(0, 5, 0);
    beat(1, 6, 0);
    beat(2, 7, 0);
    abort = 1'b1;
    beat(3, 8, 1);
    abort = 1'b0;
    n_assert++;
    if (bus.wr_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_load: ready %b err %b want 1 0",
               bus.wr_ready, err);
    end
    beat(3, 9, 1);
    n_assert++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_mask: err %b want 1", err);
    end
  endtask

  task automatic test_back_to_back();
    full_set(10, 20, 30, 40);
    bus.wr_valid = 1'b1;
    bus.wr_idx   = 3'd0;
    bus.wr_data  = 16'd777;
    bus.wr_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_assert++;
      if (bus.wr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready%0d: got %b want 0", i, bus.wr_ready);
      end
    end
    fire_epoch(pack(10, 20, 30, 40));
    n_assert++;
    if (applied !== 1'b1 || bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_applied: applied %b ready %b want 1 1",
               applied, bus.wr_ready);
    end else begin
      got = exp_q.pop_front();
      if (argsB !== got) begin
        n_fail++;
        $display("FAIL bp_args: argsB %h want %h", argsB, got);
      end
      cur_active = got;
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    beat(1, 21, 0);
    beat(2, 31, 0);
    beat(3, 41, 1);
    fire_epoch(pack(777, 21, 31, 41));
    n_assert++;
    if (applied !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_late_applied: got %b want 1", applied);
    end else begin
      got = exp_q.pop_front();
      if (argsB !== got) begin
        n_fail++;
        $display("FAIL bp_late_args: argsB %h want %h", argsB, got);
      end
      cur_active = got;
    end
  endtask

  task automatic test_reset_mid();
    beat(0, 55, 0);
    reset = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    cur_active = '0;
    n_assert++;
    if ({argsB, coef_valid, applied, err} !== '0 ||
        bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_load: argsB %h cv %b ready %b want 0 0 1",
               argsB, coef_valid, bus.wr_ready);
    end
    full_set(-1, -2, -3, -4);
    fire_epoch(pack(-1, -2, -3, -4));
    if (applied === 1'b1) cur_active = exp_q.pop_front();
    full_set(6, 7, 8, 9);
    reset = 1'b1;
    epoch = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    epoch = 1'b0;
    cur_active = '0;
    n_assert++;
    if ({argsB, coef_valid, applied, err} !== '0 ||
        bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pend: argsB %h cv %b applied %b want 0 0 0",
               argsB, coef_valid, applied);
    end
    full_set(-7, 70, -700, 7000);
    fire_epoch(pack(-7, 70, -700, 7000));
    n_assert++;
    if (applied !== 1'b1 || coef_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_recommit: applied %b cv %b want 1 1",
               applied, coef_valid);
    end else begin
      got = exp_q.pop_front();
      if (argsB !== got) begin
        n_fail++;
        $display("FAIL rst_recommit_args: argsB %h want %h", argsB, got);
      end
      cur_active = got;
    end
  endtask

  initial begin
    reset        = 1'b1;
    abort        = 1'b0;
    epoch        = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_idx   = '0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    test_reset();
    test_incomplete();
    test_commit();
    test_bad_idx();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bf_coef_loader.md
BF_COEF_LOADER -- requirements
Module: bf_coef_loader

Interface
REQ-001 SHALL have parameter NN, default 4, number of antenna channels (2..16).
REQ-002 SHALL have parameter b_width, default 16, signed coefficient width in bits.
REQ-003 SHALL have parameter IDX_W, default `CLOG2(NN)`, index width, minimum 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_valid  input  1  coefficient beat valid.
REQ-007 SHALL have port wr_ready  output  1  loader accepts a beat this cycle.
REQ-008 SHALL have port wr_idx  input  IDX_W  target antenna index.
REQ-009 SHALL have port wr_data  input  b_width  signed coefficient.
REQ-010 SHALL have port wr_last  input  1  marks the final beat of a set.
REQ-011 SHALL have port abort  input  1  discards the set being loaded.
REQ-012 SHALL have port epoch  input  1  one-cycle integration-boundary strobe.
REQ-013 SHALL have port argsB  output  NN*b_width  active coefficients, antenna i at bits [(i+1)*b_width-1 : i*b_width].
REQ-014 SHALL have port coef_valid  output  1  active bank holds a committed set.
REQ-015 SHALL have port applied  output  1  one-cycle pulse when a set is committed.
REQ-016 SHALL have port err  output  1  one-cycle pulse on a rejected beat or set.

Function
REQ-017 SHALL hold a shadow bank and an active bank of NN registers each, plus an NN-bit written-mask.
REQ-018 SHALL implement states IDLE, LOAD and PEND.
REQ-019 SHALL assert wr_ready in IDLE and LOAD, and deassert it in PEND.
REQ-020 SHALL treat a beat as accepted when wr_valid && wr_ready.
REQ-021 SHALL, on an accepted beat with wr_idx<NN, write wr_data to shadow[wr_idx] and set mask[wr_idx]; a duplicate index overwrites.
REQ-022 SHALL, on an accepted beat with wr_idx>=NN, leave shadow unchanged and pulse err the next cycle; the set continues.
REQ-023 SHALL transition IDLE->LOAD on an accepted beat without wr_last.
REQ-024 SHALL, on an accepted beat with wr_last (from IDLE or LOAD), go to PEND if the mask including this beat is all ones.
REQ-025 SHALL otherwise, in the REQ-024 case, pulse err, clear the mask and go to IDLE.
REQ-026 SHALL, in PEND on epoch=1, copy shadow to the active bank, set coef_valid=1, pulse applied, clear the mask and go to IDLE.
REQ-027 SHALL make argsB reflect the new set on the cycle after epoch is sampled, changing all NN fields in the same cycle with no partial update.
REQ-028 SHALL ignore epoch in IDLE and LOAD; argsB is unchanged.
REQ-029 SHALL, on abort=1 in LOAD or PEND, clear the mask and go to IDLE with the active bank untouched; abort takes priority over a same-cycle beat or epoch.
REQ-030 SHALL leave the active bank unmodified by any beat at all times.
REQ-031 SHALL drive argsB directly from registers, with no combinational path from inputs.

Reset
REQ-032 SHALL, when reset=1 on a clock edge, set state=IDLE, mask=0, shadow=0, active=0, argsB=0, coef_valid=0, applied=0 and err=0.
REQ-033 SHALL have reset override abort, epoch and beats, including mid-LOAD and in PEND.
REQ-034 SHALL have wr_ready=1 on the first cycle after reset deasserts.

Verification
REQ-035 SHALL pass: NN=4; write idx 0..3 = {100,-200,300,-400}, last on idx3; epoch 5 cycles later -> argsB unchanged until the cycle after epoch, then fields {100,-200,300,-400}; applied pulses once; coef_valid=1.
REQ-036 SHALL pass: write idx 0,1,3 with last on idx3 -> err pulse; state IDLE; argsB stays 0; a following epoch has no effect.
REQ-037 SHALL pass: after a committed set A, load full set B and assert abort in PEND together with epoch -> argsB still A; no applied pulse; wr_ready=1.
REQ-038 SHALL pass: beat with wr_idx=5 (NN=4) within a full set -> err pulse; set still commits on epoch with the 4 valid values.
REQ-039 SHALL pass: reset asserted mid-LOAD and again in PEND after a committed set -> all outputs 0, coef_valid=0, next full set plus epoch commits normally.
REQ-040 SHALL pass: wr_valid held high in PEND -> wr_ready=0 and no shadow change until epoch; the beat is accepted on the cycle after commit.
